// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared FSM states, segment width and active-low 7-segment glyph table
package hex_display_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low segments, bit0=a .. bit6=g, indexed by nibble value
    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {IDLE, WRITE, ADV, DONE} state_t;

endpackage

// File: rtl/hex_seg_decode.sv
// hex_seg_decode: combinational nibble to active-low 7-segment pattern
module hex_seg_decode
    import hex_display_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_display_sequencer.sv
// hex_display_sequencer: Avalon-MM master writing one segment pattern per HEX PIO; HEX_BLANK_LEADING_ZEROS_EN blanks leading zero digits
module hex_display_sequencer
    import hex_display_pkg::*;
#(
    parameter int              NUM_DIGITS  = 6,
    parameter int              ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h0000,
    parameter logic [ADDR_W-1:0] ADDR_STRIDE = 16'h0010
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    update_req,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       avm_address,
    output logic                    avm_write,
    output logic [31:0]             avm_writedata,
    input  logic                    avm_waitrequest
);

    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx;
    logic [VAL_W-1:0] val_q, pend_q;
    logic             pending, last, blank;
    logic [3:0]       nibble;
    logic [SEG_W-1:0] glyph, seg;

    assign last   = idx == LAST_IDX;
    assign nibble = 4'(val_q >> (4 * idx));

    hex_seg_decode u_dec (
        .nibble (nibble),
        .seg    (glyph)
    );

`ifdef HEX_BLANK_LEADING_ZEROS_EN
    logic [VAL_W-1:0] upper;
    assign upper = val_q >> (4 * idx);
    assign blank = idx != '0 && upper == '0;
`else
    assign blank = 1'b0;
`endif

    assign seg           = blank ? SEG_BLANK : glyph;
    assign busy          = state != IDLE;
    assign done          = state == DONE;
    assign avm_write     = state == WRITE;
    assign avm_address   = avm_write ? BASE_ADDR + ADDR_W'(idx) * ADDR_STRIDE : '0;
    assign avm_writedata = avm_write ? {{(32 - SEG_W){1'b0}}, seg} : '0;

    // Next-state: one write per digit, one idle gap between writes, re-launch from DONE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = update_req ? WRITE : IDLE;
            WRITE:   state_nx = avm_waitrequest ? WRITE : (last ? DONE : ADV);
            ADV:     state_nx = WRITE;
            DONE:    state_nx = (update_req || pending) ? WRITE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register with value latch, digit index and latest-wins pending request
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            val_q   <= '0;
            pend_q  <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ADV)
                idx <= idx + 1'b1;
            if (state == IDLE && update_req) begin
                val_q <= value_in;
                idx   <= '0;
            end
            if (state == DONE) begin
                idx     <= '0;
                pending <= 1'b0;
                if (update_req)
                    val_q <= value_in;
                else if (pending)
                    val_q <= pend_q;
            end
            if ((state == WRITE || state == ADV) && update_req) begin
                pending <= 1'b1;
                pend_q  <= value_in;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_sequencer.sv
// tb_hex_display_sequencer: scoreboard bench with a request-level reference model
module tb_hex_display_sequencer;

    localparam int N = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] value_in = '0;
    logic        update_req = 1'b0;
    logic        busy, done;
    logic [15:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;

    always #5 clk = ~clk;

    hex_display_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .value_in        (value_in),
        .update_req      (update_req),
        .busy            (busy),
        .done            (done),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t wq[$];
    int  dq[$];

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [31:0] exp_seg(input logic [23:0] v, input int i);
        logic [3:0] nib;
        nib = 4'(v >> (4 * i));
`ifdef HEX_BLANK_LEADING_ZEROS_EN
        if (i > 0 && (v >> (4 * i)) == 24'd0) return 32'h7F;
`endif
        return {25'd0, seg_tab[nib]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: which values get displayed, decided per request at the sequence level
    bit          m_active = 0;
    int          m_left = 0;
    int          m_done_at = -1;
    bit          m_pend = 0;
    logic [23:0] m_pval = '0;

    task automatic launch(input logic [23:0] v);
        m_active = 1;
        m_left   = N;
        for (int i = 0; i < N; i++) wq.push_back('{16'(i * 16), exp_seg(v, i)});
    endtask

    always @(negedge clk) begin
        if (reset) begin
            m_active = 0;
            m_left   = 0;
            m_pend   = 0;
            m_done_at = -1;
            wq.delete();
            dq.delete();
        end else begin
            if (m_active && m_left > 0 && avm_write && !avm_waitrequest) begin
                m_left--;
                if (m_left == 0) begin
                    m_done_at = cyc + 1;
                    dq.push_back(cyc + 1);
                end
            end
            if (m_active && m_left == 0 && cyc == m_done_at) begin
                if (update_req) begin
                    launch(value_in);
                    m_pend = 0;
                end else if (m_pend) begin
                    launch(m_pval);
                    m_pend = 0;
                end else begin
                    m_active = 0;
                end
            end else if (update_req) begin
                if (!m_active) launch(value_in);
                else begin
                    m_pend = 1;
                    m_pval = value_in;
                end
            end
        end
    end

    // Monitor: pops expected writes on each accepted write, checks done timing and stall stability
    bit          prev_stall = 0;
    logic [15:0] prev_addr;
    logic [31:0] prev_data;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (done) begin
                if (dq.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else check("done_cycle", 32'(cyc), 32'(dq.pop_front()));
            end
            if (dq.size() > 0 && dq[0] < cyc) begin
                check("missed_done", 32'd0, 32'(dq[0]));
                void'(dq.pop_front());
            end
            if (avm_write && prev_stall) begin
                check("stall_addr", 32'(avm_address), 32'(prev_addr));
                check("stall_data", avm_writedata, prev_data);
            end
            if (avm_write && !avm_waitrequest) begin
                if (wq.size() == 0) check("unexpected_write", 32'(avm_address), 32'hFFFF_FFFF);
                else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_addr", 32'(avm_address), 32'(e.addr));
                    check("wr_data", avm_writedata, e.data);
                end
            end
            prev_stall = avm_write && avm_waitrequest;
            prev_addr  = avm_address;
            prev_data  = avm_writedata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [23:0] v, output int c0);
        c0 = cyc;
        value_in = v;
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
    endtask

    task automatic wait_done(input int c0, input int exp_lat, input string name);
        int got;
        got = -1;
        for (int k = 0; k < 60 && got < 0; k++) begin
            @(negedge clk);
            if (done) got = cyc - c0;
        end
        check(name, 32'(got), 32'(exp_lat));
        tick();
    endtask

    task automatic count_done(input int cycles, input int exp_n, input string name);
        int n;
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) n++;
        end
        check(name, 32'(n), 32'(exp_n));
        tick();
    endtask

    initial begin
        int c0, c1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_write", 32'(avm_write), 0);
        check("rst_addr", 32'(avm_address), 0);
        check("rst_data", avm_writedata, 0);
        tick();
        reset = 1'b0;
        repeat (2) tick();

        start(24'h0123AB, c0);
        @(negedge clk);
        check("first_write", 32'(avm_write), 1);
        check("first_addr", 32'(avm_address), 0);
        check("first_busy", 32'(busy), 1);
        wait_done(c0, 12, "latency_nostall");

        start(24'h888888, c0);
        repeat (4) tick();
        avm_waitrequest = 1'b1;
        repeat (3) tick();
        avm_waitrequest = 1'b0;
        wait_done(c0, 15, "latency_stall");

        start(24'h111111, c0);
        repeat (3) tick();
        start(24'h222222, c1);
        repeat (2) tick();
        start(24'h333333, c1);
        count_done(40, 2, "pending_done_count");

        start(24'h456789, c0);
        repeat (6) tick();
        avm_waitrequest = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        @(negedge clk);
        check("abort_write", 32'(avm_write), 0);
        check("abort_busy", 32'(busy), 0);
        count_done(20, 0, "abort_no_done");
        start(24'hABCDEF, c0);
        @(negedge clk);
        check("restart_addr", 32'(avm_address), 0);
        check("restart_write", 32'(avm_write), 1);
        wait_done(c0, 12, "restart_latency");

        start(24'h00002F, c0);
        wait_done(c0, 12, "blank_2f_latency");
        start(24'h000000, c0);
        wait_done(c0, 12, "blank_0_latency");

        start(24'h001234, c0);
        repeat (11) tick();
        value_in = 24'hFEDCBA;
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
        @(negedge clk);
        check("relaunch_write", 32'(avm_write), 1);
        check("relaunch_addr", 32'(avm_address), 0);
        check("relaunch_data", avm_writedata, exp_seg(24'hFEDCBA, 0));
        wait_done(c0, 24, "relaunch_latency");
        count_done(20, 0, "relaunch_no_extra");

        repeat (400) begin
            update_req = ($urandom_range(7) == 0);
            value_in = 24'($urandom >> $urandom_range(31));
            avm_waitrequest = ($urandom_range(2) == 0);
            tick();
        end
        update_req = 1'b0;
        avm_waitrequest = 1'b0;
        repeat (60) tick();

        check("wq_empty", 32'(wq.size()), 0);
        check("dq_empty", 32'(dq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
